jts16_rom_cache2: RTL
=====================

Name: jts16_rom_cache2

Overview:
- Two-entry, tagged read-cache slot between one graphics/sound consumer and one SDRAM bank port (ba_rd[n], ba_ack[n], ba_dst[n], ba_rdy[n], data_read).
- Gives repeated reads to the same ROM word single-cycle service with no SDRAM traffic.
- Misses become one burst request; returned 16-bit words are packed to DW.
- Standalone drop-in alternative to the single-slot ROM readers on banks 1–3 (e.g. obj ROM on bank 3).

Parameters:
- AW, 20, slot address width in DW-sized units.
- DW, 16, slot data width: 8, 16 or 32.
- OFFSET, 22'h0, word offset added to the SDRAM address.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- slot_addr  in  AW  consumer address.
- slot_cs  in  1  consumer read request, level.
- slot_clr  in  1  invalidate both entries; pulse after download.
- slot_ok  out  1  slot_dout is valid for the current slot_addr.
- slot_dout  out  DW  read data.
- sdram_addr  out  22  SDRAM word address.
- sdram_req  out  1  read request to bank.
- sdram_ack  in  1  request accepted, one-cycle pulse.
- data_dst  in  1  first data word present on data_read.
- data_rdy  in  1  last data word present and transaction done.
- data_read  in  16  SDRAM read bus, shared by all banks.

Behaviour:
- Reset values:
  - slot_ok=0, slot_dout=0, sdram_req=0, sdram_addr=0.
  - Both valid bits=0, LRU pointer=0, FSM=IDLE.
- Address mapping:
  - DW=8: word address = slot_addr[AW-1:1]; the byte lane is selected by slot_addr[0], where 0 = low byte.
  - DW=16: word address = slot_addr.
  - DW=32: word address = {slot_addr,1'b0}.
  - sdram_addr = word address zero-extended to 22 bits, plus OFFSET, modulo 2^22.
- Tags store the full slot address, minus bit 0 when DW=8.
- Hit:
  - Condition: slot_cs=1, entry valid, and tag matches.
  - Next cycle: slot_ok=1 and slot_dout = entry data. Latency is 1 clock.
  - The hit entry becomes MRU.
- slot_ok falls one cycle after slot_cs falls or slot_addr changes to a non-hit. It never stays high for a stale address.
- FSM:
  - IDLE -> REQ: on slot_cs with a miss. Latch the miss address; drive sdram_addr and sdram_req=1.
  - REQ -> WAIT: on sdram_ack; sdram_req drops in the same edge. sdram_req stays high until ack and never reasserts before the FSM returns to IDLE.
  - WAIT -> FILL: on data_dst; capture data_read as word 0.
  - FILL:
    - Capture one word per clock until DW/16 words are held.
    - For DW<=16 this is a single word, captured at dst.
    - DW=32: word 0 = bits [15:0], word 1 = bits [31:16].
  - FILL -> IDLE: on data_rdy with all words held. Write the LRU entry (data, tag, valid=1); it becomes MRU. If slot_cs is still high and slot_addr still matches, slot_ok rises the next cycle.
- Address change mid-fetch: the fetch always completes and fills the cache; the new address is served afterwards.
- slot_cs dropped mid-fetch: the fetch completes and the entry is filled; slot_ok stays 0.
- slot_clr:
  - Clears both valid bits and forces slot_ok=0 next cycle.
  - If it arrives during a fetch, the in-flight fill is discarded (valid not set).
  - slot_clr together with a hit in the same cycle: clr wins.
- data_dst/data_rdy are ignored outside WAIT/FILL, because other banks share data_read.
- Async reset mid-transaction returns to the reset values immediately. No request is left asserted.

Decomposition:
- Shared package jts16_mem_pkg: FSM state enum (IDLE/REQ/WAIT/FILL), SDRAM address width 22, DW-to-words-per-fill function.
- One sub-module, jts16_cache_entry: tag/data/valid register with match output; instantiated twice.
- LRU and FSM live in the top module.

Test Plan:
- Miss then hit, DW=16:
  - Stimulus: addr=20'h00123, cs=1. Bench acks 3 cycles later, then dst+rdy with data 16'hBEEF.
  - Required: one req with sdram_addr=22'h000123. ok=1 next cycle with dout=16'hBEEF.
  - Re-read: req stays 0, ok in 1 cycle.
- DW=32, OFFSET=22'h10_0000, addr=19'h00010:
  - Required: sdram_addr=22'h10_0020.
  - Bench returns 16'h1111 at dst and 16'h2222 with rdy. Required: dout=32'h2222_1111.
- LRU replacement: access A, B, A, then C.
  - Required: C evicts B. A hits (no req); B misses (req issued).
- DW=8: addr 0x0A1 then 0x0A0, word 16'h55AA.
  - Required: a single SDRAM fetch. dout=8'h55, then 8'hAA; second access hits.
- slot_clr:
  - Pulsed during WAIT for addr X: the fill completes but the next access to X issues a new req.
  - Pulsed while ok=1: ok=0 next cycle.
- Async rst asserted while sdram_req=1:
  - Required: sdram_req=0 and ok=0 immediately.
  - Post-reset access to a previously cached address issues a req.
  - Stray data_dst/data_rdy pulses while IDLE leave the cache unchanged.

Source files
------------

// File: rtl/jts16_mem_pkg.sv
// Shared definitions for the SDRAM ROM cache: fetch FSM states, SDRAM address width,
// and the number of 16-bit SDRAM words needed to build one DW-wide slot word.
package jts16_mem_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FILL
  } fetch_st_e;

  // 32-bit slots need two SDRAM words; 8- and 16-bit slots fit in one.
  function automatic int words_per_fill(input int dw);
    return (dw == 32) ? 2 : 1;
  endfunction

endpackage

// File: rtl/jts16_cache_entry.sv
// One cache line: a valid bit, an address tag and the fetched data.
// match_o is combinational from the stored state. Clear takes priority over write,
// so a line cannot be re-validated in the same cycle as an invalidate.
module jts16_cache_entry
  import jts16_mem_pkg::*;
#(
  parameter int TW = 20,
  parameter int EW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [TW-1:0] wr_tag_i,
  input  logic [EW-1:0] wr_data_i,
  input  logic [TW-1:0] look_tag_i,
  output logic          match_o,
  output logic [EW-1:0] data_o
);

  logic          valid_q;
  logic [TW-1:0] tag_q;
  logic [EW-1:0] data_q;

  // Line storage; the tag and data are only meaningful while valid_q is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (clr_i) begin
        valid_q <= 1'b0;
      end else if (wr_i) begin
        valid_q <= 1'b1;
      end
      if (wr_i) begin
        tag_q  <= wr_tag_i;
        data_q <= wr_data_i;
      end
    end
  end

  assign match_o = valid_q && (tag_q == look_tag_i);
  assign data_o  = data_q;

endmodule

// File: rtl/jts16_rom_cache2.sv
// Two-entry LRU read cache between a ROM consumer slot and one SDRAM bank port.
// Hits answer one clock after the request; a miss issues a single burst request,
// packs the returned 16-bit words to DW and writes the least recently used entry.
module jts16_rom_cache2
  import jts16_mem_pkg::*;
#(
  parameter int                  AW     = 20,
  parameter int                  DW     = 16,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       slot_addr,
  input  logic                slot_cs,
  input  logic                slot_clr,
  output logic                slot_ok,
  output logic [DW-1:0]       slot_dout,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);

  localparam int NW = words_per_fill(DW);
  localparam int EW = 16 * NW;
  // Byte slots share one 16-bit line between two addresses, so bit 0 is not tagged.
  localparam int TW = (DW == 8) ? AW - 1 : AW;
  localparam int WW = (DW == 32) ? AW + 1 : TW;
  localparam logic [1:0] NWC = 2'(NW);

  fetch_st_e st_q, st_d;
  logic                  req_q, req_d;
  logic [SDRAM_AW-1:0]   addr_q, addr_d;
  logic [TW-1:0]         miss_tag_q, miss_tag_d;
  logic [NW-1:0][15:0]   fill_q, fill_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  discard_q, discard_d;
  logic                  lru_q, lru_d;
  logic                  ok_q, ok_d;
  logic [DW-1:0]         dout_q, dout_d;

  logic [TW-1:0]         tag_now;
  logic [WW-1:0]         word_addr;
  logic [SDRAM_AW-1:0]   req_addr;
  logic                  m0, m1, hit, complete, fill_wr;
  logic [EW-1:0]         e0_data, e1_data, hit_data, fill_data;
  logic [DW-1:0]         hit_word, fill_word;

  if (DW == 8) begin : g_map8
    assign tag_now   = slot_addr[AW-1:1];
    assign word_addr = slot_addr[AW-1:1];
    assign hit_word  = slot_addr[0] ? hit_data[15:8] : hit_data[7:0];
    assign fill_word = slot_addr[0] ? fill_data[15:8] : fill_data[7:0];
  end else if (DW == 32) begin : g_map32
    assign tag_now   = slot_addr;
    assign word_addr = {slot_addr, 1'b0};
    assign hit_word  = hit_data;
    assign fill_word = fill_data;
  end else begin : g_map16
    assign tag_now   = slot_addr;
    assign word_addr = slot_addr;
    assign hit_word  = hit_data;
    assign fill_word = fill_data;
  end

  assign req_addr  = SDRAM_AW'(word_addr) + OFFSET;
  assign hit       = slot_cs && (m0 || m1);
  assign hit_data  = m0 ? e0_data : e1_data;
  assign fill_data = fill_d;
  // A clear seen at any point of the fetch, including its last cycle, drops the fill.
  assign fill_wr   = complete && !discard_q && !slot_clr;

  jts16_cache_entry #(.TW(TW), .EW(EW)) u_entry0 (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (slot_clr),
    .wr_i       (fill_wr && !lru_q),
    .wr_tag_i   (miss_tag_q),
    .wr_data_i  (fill_data),
    .look_tag_i (tag_now),
    .match_o    (m0),
    .data_o     (e0_data)
  );

  jts16_cache_entry #(.TW(TW), .EW(EW)) u_entry1 (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (slot_clr),
    .wr_i       (fill_wr && lru_q),
    .wr_tag_i   (miss_tag_q),
    .wr_data_i  (fill_data),
    .look_tag_i (tag_now),
    .match_o    (m1),
    .data_o     (e1_data)
  );

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // Fetch FSM: request, wait for the burst, collect words; dst/rdy only count in WAIT/FILL.
  always_comb begin
    st_d       = st_q;
    req_d      = req_q;
    addr_d     = addr_q;
    miss_tag_d = miss_tag_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q | slot_clr;
    complete   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (slot_cs && !(m0 || m1)) begin
          st_d       = ST_REQ;
          req_d      = 1'b1;
          addr_d     = req_addr;
          miss_tag_d = tag_now;
          cnt_d      = 2'd0;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          st_d  = ST_WAIT;
          req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (data_dst) begin
          fill_d[0] = data_read;
          cnt_d     = 2'd1;
          // Single-word bursts may flag dst and rdy together.
          if (data_rdy && (NW == 1)) complete = 1'b1;
          else                       st_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (cnt_q < NWC) begin
          fill_d[NW-1] = data_read;
          cnt_d        = cnt_q + 2'd1;
        end
        if (data_rdy && (cnt_d >= NWC)) complete = 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase
    if (complete) st_d = ST_IDLE;
  end

  // Consumer response and LRU: a fill for the address still being asked for is
  // forwarded straight to the output; a clear suppresses any response that cycle.
  always_comb begin
    lru_d  = lru_q;
    ok_d   = 1'b0;
    dout_d = dout_q;
    if (fill_wr)                lru_d = ~lru_q;
    else if (hit && !slot_clr) lru_d = m0;
    if (!slot_clr) begin
      if (fill_wr && slot_cs && (tag_now == miss_tag_q)) begin
        ok_d   = 1'b1;
        dout_d = fill_word;
      end else if (hit) begin
        ok_d   = 1'b1;
        dout_d = hit_word;
      end
    end
  end

  // Datapath and fetch bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      miss_tag_q <= '0;
      fill_q     <= '0;
      cnt_q      <= 2'd0;
      discard_q  <= 1'b0;
      lru_q      <= 1'b0;
      ok_q       <= 1'b0;
      dout_q     <= '0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      miss_tag_q <= miss_tag_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      lru_q      <= lru_d;
      ok_q       <= ok_d;
      dout_q     <= dout_d;
    end
  end

  assign slot_ok    = ok_q;
  assign slot_dout  = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule
